idp_sequencer: RTL and testbench

Instruction sequencer for the 16-bit integer datapath (8-entry register file, S/DS input mux, 4-bit-opcode ALU with C/N/Z flags). It accepts 16-bit micro-instructions over a valid/ready handshake and drives the datapath control ports cycle by cycle: single register ops, immediate loads through DS, repeated ops on one register, and a full register-file clear. It captures ALU flags on every write and sits between the instruction source and the datapath's control inputs.

---
 rtl/idp_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_idp_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/idp_sequencer.sv
// Micro-instruction sequencer for the 16-bit integer datapath: accepts one
// instruction at a time and drives registered register-file/ALU controls.
module idp_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        busy,
    output logic        done,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic [2:0]  flags,
    output logic        we,
    output logic [2:0]  W_adr,
    output logic [2:0]  R_adr,
    output logic [2:0]  S_adr,
    output logic [15:0] DS,
    output logic        sel,
    output logic [3:0]  ALU_OP
);

    localparam logic [3:0] PASS_S_OP = 4'b0000;

    localparam logic [1:0] CLS_REG    = 2'b00;
    localparam logic [1:0] CLS_LOADI  = 2'b01;
    localparam logic [1:0] CLS_REPEAT = 2'b10;
    localparam logic [1:0] CLS_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_LOOP = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic        clear_mode_reg;
    logic        ready_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [2:0]  flags_reg;
    logic        we_reg;
    logic [2:0]  w_adr_reg;
    logic [2:0]  r_adr_reg;
    logic [2:0]  s_adr_reg;
    logic [15:0] ds_reg;
    logic        sel_reg;
    logic [3:0]  alu_op_reg;

    logic [1:0]  instr_class;
    logic [3:0]  repeat_count;
    logic        accept;
    logic        last_cycle;
    logic        unused_instr_bit;

    assign instr_class      = instr[15:14];
    assign repeat_count     = instr[6:3];
    assign accept           = (state_reg == ST_IDLE) && instr_valid;
    // The final write cycle of any instruction; the next edge returns to IDLE.
    assign last_cycle       = (state_reg == ST_EXEC) ||
                              ((state_reg == ST_LOOP) && (count_reg == 4'd0));
    assign unused_instr_bit = instr[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= 4'd0;
            clear_mode_reg <= 1'b0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            flags_reg      <= 3'b000;
            we_reg         <= 1'b0;
            w_adr_reg      <= 3'd0;
            r_adr_reg      <= 3'd0;
            s_adr_reg      <= 3'd0;
            ds_reg         <= 16'h0000;
            sel_reg        <= 1'b0;
            alu_op_reg     <= 4'd0;
        end else begin
            // Flags reflect the ALU result of whichever write is completing now.
            if (we_reg) begin
                flags_reg <= {C, N, Z};
            end

            if (accept) begin
                ready_reg <= 1'b0;
                busy_reg  <= 1'b1;
                we_reg    <= 1'b1;
                case (instr_class)
                    CLS_REG: begin
                        state_reg      <= ST_EXEC;
                        done_reg       <= 1'b1;
                        alu_op_reg     <= instr[13:10];
                        w_adr_reg      <= instr[9:7];
                        r_adr_reg      <= instr[6:4];
                        s_adr_reg      <= instr[3:1];
                        ds_reg         <= 16'h0000;
                        sel_reg        <= 1'b0;
                        clear_mode_reg <= 1'b0;
                        count_reg      <= 4'd0;
                    end
                    CLS_LOADI: begin
                        state_reg      <= ST_EXEC;
                        done_reg       <= 1'b1;
                        alu_op_reg     <= PASS_S_OP;
                        w_adr_reg      <= instr[13:11];
                        r_adr_reg      <= 3'd0;
                        s_adr_reg      <= 3'd0;
                        ds_reg         <= {5'b0, instr[10:0]};
                        sel_reg        <= 1'b1;
                        clear_mode_reg <= 1'b0;
                        count_reg      <= 4'd0;
                    end
                    CLS_REPEAT: begin
                        state_reg      <= ST_LOOP;
                        done_reg       <= (repeat_count == 4'd0);
                        alu_op_reg     <= instr[13:10];
                        w_adr_reg      <= instr[9:7];
                        r_adr_reg      <= instr[9:7];
                        s_adr_reg      <= instr[2:0];
                        ds_reg         <= 16'h0000;
                        sel_reg        <= 1'b0;
                        clear_mode_reg <= 1'b0;
                        count_reg      <= repeat_count;
                    end
                    default: begin
                        state_reg      <= ST_LOOP;
                        done_reg       <= 1'b0;
                        alu_op_reg     <= PASS_S_OP;
                        w_adr_reg      <= 3'd0;
                        r_adr_reg      <= 3'd0;
                        s_adr_reg      <= 3'd0;
                        ds_reg         <= 16'h0000;
                        sel_reg        <= 1'b1;
                        clear_mode_reg <= 1'b1;
                        count_reg      <= 4'd7;
                    end
                endcase
            end else if (last_cycle) begin
                state_reg      <= ST_IDLE;
                count_reg      <= 4'd0;
                clear_mode_reg <= 1'b0;
                ready_reg      <= 1'b1;
                busy_reg       <= 1'b0;
                done_reg       <= 1'b0;
                we_reg         <= 1'b0;
                w_adr_reg      <= 3'd0;
                r_adr_reg      <= 3'd0;
                s_adr_reg      <= 3'd0;
                ds_reg         <= 16'h0000;
                sel_reg        <= 1'b0;
                alu_op_reg     <= 4'd0;
            end else if (state_reg == ST_LOOP) begin
                count_reg <= count_reg - 4'd1;
                done_reg  <= (count_reg == 4'd1);
                if (clear_mode_reg) begin
                    w_adr_reg <= w_adr_reg + 3'd1;
                end
            end
        end
    end

    // CLS_REPEAT/CLS_CLEAR share the LOOP path; CLS_CLEAR is the default arm.
    logic unused_cls;
    assign unused_cls = (CLS_CLEAR == 2'b11) && (CLS_REPEAT == 2'b10);

    assign instr_ready = ready_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign flags       = flags_reg;
    assign we          = we_reg;
    assign W_adr       = w_adr_reg;
    assign R_adr       = r_adr_reg;
    assign S_adr       = s_adr_reg;
    assign DS          = ds_reg;
    assign sel         = sel_reg;
    assign ALU_OP      = alu_op_reg;

endmodule

// File: tb/tb_idp_sequencer.sv
// Directed bench for idp_sequencer with a behavioural register file and ALU
// (op 0 pass S, op 1 add, op 2 sub R-S) closing the flag loop.
module tb_idp_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        busy;
    logic        done;
    logic        C, N, Z;
    logic [2:0]  flags;
    logic        we;
    logic [2:0]  W_adr, R_adr, S_adr;
    logic [15:0] DS;
    logic        sel;
    logic [3:0]  ALU_OP;

    int checks = 0;
    int errors = 0;

    idp_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .busy       (busy),
        .done       (done),
        .C          (C),
        .N          (N),
        .Z          (Z),
        .flags      (flags),
        .we         (we),
        .W_adr      (W_adr),
        .R_adr      (R_adr),
        .S_adr      (S_adr),
        .DS         (DS),
        .sel        (sel),
        .ALU_OP     (ALU_OP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model
    logic [15:0] rf [8];
    logic [15:0] s_val, r_val, y_val;
    logic        alu_c;

    always_comb begin
        s_val = sel ? DS : rf[S_adr];
        r_val = rf[R_adr];
        alu_c = 1'b0;
        y_val = 16'h0000;
        case (ALU_OP)
            4'd0:    y_val = s_val;
            4'd1:    {alu_c, y_val} = {1'b0, r_val} + {1'b0, s_val};
            4'd2:    {alu_c, y_val} = {1'b0, r_val} - {1'b0, s_val};
            default: y_val = r_val;
        endcase
    end
    assign C = alu_c;
    assign N = y_val[15];
    assign Z = (y_val == 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (we) begin
            rf[W_adr] <= y_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] v);
        instr       = v;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        $display("issued instr=%h", v);
    endtask

    initial begin
        logic [15:0] v;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        step();
        step();
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", flags, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", {W_adr, R_adr, S_adr}, 0);
        chk("rst_ds_sel_op", {DS, sel, ALU_OP}, 0);
        reset = 1'b0;
        step();

        // LOADI R1 = 5
        instr = 16'h4805; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0; instr = 16'hFFFF;
        chk("loadi_we", we, 1);
        chk("loadi_wadr", W_adr, 1);
        chk("loadi_sel", sel, 1);
        chk("loadi_ds", DS, 16'h0005);
        chk("loadi_op", ALU_OP, 0);
        chk("loadi_done", done, 1);
        chk("loadi_busy", busy, 1);
        chk("loadi_ready_low", instr_ready, 0);
        step();
        chk("loadi_r1", rf[1], 16'h0005);
        chk("loadi_ready_back", instr_ready, 1);
        chk("loadi_we_off", we, 0);
        chk("loadi_done_off", done, 0);
        $display("txn LOADI R1=5 done");

        // REG add R3 = R1 + R2
        issue(16'h4803);
        issue(16'h5001);
        instr = 16'h0594; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("reg_addr", {W_adr, R_adr, S_adr}, {3'd3, 3'd1, 3'd2});
        chk("reg_sel", sel, 0);
        chk("reg_op", ALU_OP, 1);
        chk("reg_we_done", {we, done}, 2'b11);
        step();
        chk("reg_r3", rf[3], 16'h0004);
        chk("reg_flags", flags, 3'b000);
        $display("txn REG add R3=R1+R2 done");

        // REPEAT add R1 += R2, count 4 -> five writes
        issue(16'h4803);
        instr = 16'h84A2; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("rep_we_%0d", i), we, (i < 5) ? 1 : 0);
            chk($sformatf("rep_done_%0d", i), done, (i == 4) ? 1 : 0);
            step();
        end
        chk("rep_r1", rf[1], 16'h0008);
        chk("rep_flags", flags, 3'b000);
        $display("txn REPEAT add x5 done");

        // Fill all registers, then CLEAR
        for (int i = 0; i < 8; i++) begin
            v = 16'h4000 | 16'(i << 11) | 16'(i + 1);
            issue(v);
        end
        chk("fill_r7", rf[7], 16'h0008);
        instr = 16'hC000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clr_we_%0d", i), we, 1);
            chk($sformatf("clr_wadr_%0d", i), W_adr, i);
            chk($sformatf("clr_done_%0d", i), done, (i == 7) ? 1 : 0);
            step();
        end
        chk("clr_we_off", we, 0);
        chk("clr_ready", instr_ready, 1);
        chk("clr_flags", flags, 3'b001);
        for (int i = 0; i < 8; i++) chk($sformatf("clr_r%0d", i), rf[i], 0);
        $display("txn CLEAR done");

        // Continuous valid across two instructions
        instr = 16'h6009; instr_valid = 1'b1;
        step();
        chk("b2b_first_we", we, 1);
        chk("b2b_first_wadr", W_adr, 4);
        instr = 16'h6807;
        step();
        chk("b2b_gap_we", we, 0);
        chk("b2b_gap_ready", instr_ready, 1);
        chk("b2b_r4", rf[4], 16'h0009);
        step();
        instr_valid = 1'b0;
        chk("b2b_second_we", we, 1);
        chk("b2b_second_wadr", W_adr, 5);
        chk("b2b_second_ds", DS, 16'h0007);
        step();
        chk("b2b_r5", rf[5], 16'h0007);
        $display("txn back-to-back LOADI pair done");

        // Reset in the 3rd cycle of a 16-iteration REPEAT sub
        issue(16'h4800);
        issue(16'h5001);
        instr = 16'h88FA; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        chk("rr_cycle3_we", we, 1);
        chk("rr_cycle3_flags", flags, 3'b010);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rr_we", we, 0);
        chk("rr_busy", busy, 0);
        chk("rr_flags", flags, 0);
        chk("rr_ready", instr_ready, 1);
        step();
        chk("rr_idle_we", we, 0);
        instr = 16'h77FF; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("rr_loadi_we_done", {we, done}, 2'b11);
        chk("rr_loadi_wadr", W_adr, 6);
        chk("rr_loadi_ds", DS, 16'h07FF);
        step();
        chk("rr_loadi_r6", rf[6], 16'h07FF);
        chk("rr_loadi_ready", instr_ready, 1);
        $display("txn reset mid-REPEAT then LOADI done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
